decode_queue: RTL and testbench

//  Decode stage directly downstream of fetch. Accepts {pc, instr} from fetch,

---
 rtl/decode_queue_if.sv | 29 ++
 rtl/decode_queue.sv | 126 ++++++++++++
 tb/tb_decode_queue.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/decode_queue_if.sv
// Fetch-to-decode and decode-to-dispatch handshake bundle.
// Ports: in_* (fetch side, valid/ready), out_* (dispatch side, valid/ready).
interface decode_queue_if;
  logic       in_valid;
  logic [7:0] in_pc;
  logic [7:0] in_instr;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pc;
  logic [2:0] out_op;
  logic [1:0] out_rd;
  logic [1:0] out_rs;
  logic [7:0] out_imm;
  logic       out_wr_en;
  logic       out_halt;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_op,
    input  out_rd, out_rs, out_imm, out_wr_en, out_halt
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_op,
    output out_rd, out_rs, out_imm, out_wr_en, out_halt
  );
endinterface

// File: rtl/decode_queue.sv
// Decode stage: decodes 8-bit instrs at enqueue into an in-order FIFO.
// Ports: clk, rst, flush, q (slave handshake bundle), count, halted.
module decode_queue #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  decode_queue_if.slave q,
  output logic [AW:0]   count,
  output logic          halted
);

  typedef struct packed {
    logic [7:0] pc;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic       wr_en;
    logic       halt;
  } entry_t;

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  entry_t        dec;
  entry_t        head;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  state_t        state_q;
  state_t        state_d;
  logic          enq;
  logic          deq;
  logic          is_nop;
  logic          is_halt;
  logic          is_li;

  assign is_nop  = q.in_instr[7:5] == 3'd0;
  assign is_halt = q.in_instr[7:5] == 3'd7;
  assign is_li   = q.in_instr[7:5] == 3'd5;

  always_comb begin
    dec    = '0;
    dec.pc = q.in_pc;
    dec.op = q.in_instr[7:5];
    unique case (1'b1)
      is_nop: ;
      is_halt: dec.halt = 1'b1;
      is_li: begin
        dec.rd    = q.in_instr[4:3];
        dec.imm   = {5'b0, q.in_instr[2:0]};
        dec.wr_en = 1'b1;
      end
      default: begin
        dec.rd    = q.in_instr[4:3];
        dec.rs    = q.in_instr[2:1];
        dec.wr_en = 1'b1;
      end
    endcase
  end

  // Full queue refuses even if dispatch drains this cycle.
  assign q.in_ready = !rst && (count != FULL) &&
                      (state_q == RUN) && !flush;
  assign q.out_valid = count != '0;
  assign enq = q.in_valid && q.in_ready;
  assign deq = q.out_valid && q.out_ready && !flush;
  assign halted = state_q == HALTED;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:    if (enq && dec.halt) state_d = HALTED;
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase
    if (flush) state_d = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      unique case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wptr] <= dec;
  end

  always_comb begin
    head = '0;
    if (q.out_valid) head = mem[rptr];
  end

  assign q.out_pc    = head.pc;
  assign q.out_op    = head.op;
  assign q.out_rd    = head.rd;
  assign q.out_rs    = head.rs;
  assign q.out_imm   = head.imm;
  assign q.out_wr_en = head.wr_en;
  assign q.out_halt  = head.halt;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: vector table, corner sequences, random vs model.
// Drives the handshake interface and the clk/rst/flush/count/halted ports.
module tb_decode_queue;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [2:0] count;
  logic       halted;
  int         total = 0;
  int         bad = 0;

  decode_queue_if dq ();

  decode_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .q(dq.slave), .count(count), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pc;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic       wr;
    logic       hlt;
  } exp_t;

  typedef struct packed {
    logic        fl;
    logic        iv;
    logic [7:0]  pc;
    logic [7:0]  ins;
    logic        ordy;
    logic [30:0] e;
  } vec_t;

  exp_t mq[$];
  bit   mhalt = 0;
  vec_t vq[$];

  function automatic logic [30:0] pk(
    logic ov, logic [7:0] pc, logic [2:0] op, logic [1:0] rd,
    logic [1:0] rs, logic [7:0] imm, logic wr, logic hlt,
    logic [2:0] cnt, logic rdy, logic hal);
    return {ov, pc, op, rd, rs, imm, wr, hlt, cnt, rdy, hal};
  endfunction

  function automatic logic [30:0] act();
    return pk(dq.out_valid, dq.out_pc, dq.out_op, dq.out_rd,
              dq.out_rs, dq.out_imm, dq.out_wr_en, dq.out_halt,
              count, dq.in_ready, halted);
  endfunction

  function automatic exp_t decode(logic [7:0] pc, logic [7:0] ins);
    exp_t d;
    d = '0;
    d.pc = pc;
    d.op = ins[7:5];
    case (ins[7:5])
      3'd0: ;
      3'd7: d.hlt = 1'b1;
      3'd5: begin
        d.rd = ins[4:3];
        d.imm = {5'b0, ins[2:0]};
        d.wr = 1'b1;
      end
      default: begin
        d.rd = ins[4:3];
        d.rs = ins[2:1];
        d.wr = 1'b1;
      end
    endcase
    return d;
  endfunction

  function automatic logic mrdy(logic fl);
    return (mq.size() < 4) && !mhalt && !fl;
  endfunction

  function automatic logic [30:0] mexp(logic fl);
    exp_t h;
    int n;
    n = mq.size();
    h = '0;
    if (n > 0) h = mq[0];
    return pk(n > 0, h.pc, h.op, h.rd, h.rs, h.imm, h.wr, h.hlt,
              3'(n), mrdy(fl), mhalt);
  endfunction

  task automatic chk(string nm, logic [30:0] a, logic [30:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic drive(logic fl, logic iv, logic [7:0] pc,
                       logic [7:0] ins, logic ordy);
    flush = fl;
    dq.in_valid = iv;
    dq.in_pc = pc;
    dq.in_instr = ins;
    dq.out_ready = ordy;
  endtask

  task automatic step(logic fl, logic iv, logic [7:0] pc,
                      logic [7:0] ins, logic ordy);
    logic take;
    logic pop;
    drive(fl, iv, pc, ins, ordy);
    #1;
    chk("model", act(), mexp(fl));
    take = iv && mrdy(fl);
    pop = (mq.size() > 0) && ordy;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      mhalt = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (take) begin
        mq.push_back(decode(pc, ins));
        if (ins[7:5] == 3'd7) mhalt = 1;
      end
    end
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    vq.push_back('{0, 1, 8'h10, 8'h3A, 0,
      pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vq.push_back('{0, 1, 8'h11, 8'hAD, 1,
      pk(1, 8'h10, 1, 3, 1, 0, 1, 0, 1, 1, 0)});
    vq.push_back('{0, 1, 8'h12, 8'hE0, 0,
      pk(1, 8'h11, 5, 1, 0, 5, 1, 0, 1, 1, 0)});
    vq.push_back('{0, 1, 8'h13, 8'h20, 1,
      pk(1, 8'h11, 5, 1, 0, 5, 1, 0, 2, 0, 1)});
    vq.push_back('{0, 0, 8'h00, 8'h00, 0,
      pk(1, 8'h12, 7, 0, 0, 0, 0, 1, 1, 0, 1)});
    vq.push_back('{1, 1, 8'h14, 8'h3A, 1,
      pk(1, 8'h12, 7, 0, 0, 0, 0, 1, 1, 0, 1)});
    vq.push_back('{0, 1, 8'h20, 8'h56, 0,
      pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vq.push_back('{0, 0, 8'h00, 8'h00, 1,
      pk(1, 8'h20, 2, 2, 3, 0, 1, 0, 1, 1, 0)});
    vq.push_back('{0, 1, 8'h21, 8'h1F, 0,
      pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vq.push_back('{0, 0, 8'h00, 8'h00, 1,
      pk(1, 8'h21, 0, 0, 0, 0, 0, 0, 1, 1, 0)});
    vq.push_back('{0, 1, 8'h30, 8'hDE, 0,
      pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vq.push_back('{0, 0, 8'h00, 8'h00, 1,
      pk(1, 8'h30, 6, 3, 3, 0, 1, 0, 1, 1, 0)});
    vq.push_back('{0, 0, 8'h00, 8'h00, 0,
      pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", act(), '0);
    rst = 1'b0;
    #1;
    chk("reset_rel", act(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    foreach (vq[i]) begin
      drive(vq[i].fl, vq[i].iv, vq[i].pc, vq[i].ins, vq[i].ordy);
      #1;
      chk($sformatf("vec%0d", i), act(), vq[i].e);
      step(vq[i].fl, vq[i].iv, vq[i].pc, vq[i].ins, vq[i].ordy);
    end

    for (int i = 0; i < 5; i++)
      step(0, 1, 8'h40 + 8'(i), 8'h20 + 8'(i), 0);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("fill_count", 31'(count), 31'd4);
    chk("fill_ready", 31'(dq.in_ready), 31'd0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1);
      #1;
      chk("drain_pc", 31'(dq.out_pc), 31'(8'h40 + 8'(i)));
      step(0, 0, 0, 0, 1);
    end
    chk("drain_empty", 31'(dq.out_valid), 31'd0);

    for (int i = 0; i < 4; i++)
      step(0, 1, 8'h50 + 8'(i), 8'h48, 0);
    step(0, 1, 8'h54, 8'h25, 1);
    chk("full_deq_only", 31'(count), 31'd3);
    step(0, 1, 8'h54, 8'h25, 0);
    chk("next_accept", 31'(count), 31'd4);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 8'h55, 8'h66, 1);
    chk("enq_deq_hold", 31'(count), 31'd2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

    for (int i = 0; i < 3; i++)
      step(0, 1, 8'h60 + 8'(i), 8'h3A, 0);
    step(1, 1, 8'h70, 8'h3A, 1);
    chk("flush_cnt", 31'(count), 31'd0);
    chk("flush_ov", 31'(dq.out_valid), 31'd0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    step(0, 1, 8'h80, 8'h3A, 0);
    step(0, 1, 8'h81, 8'hE0, 0);
    drive(0, 1, 8'h82, 8'h3A, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid", act(), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    #1;
    chk("rst_mid_rel", act(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    mq.delete();
    mhalt = 0;

    for (int i = 0; i < 400; i++)
      step($urandom_range(15) == 0, 1'($urandom), 8'($urandom),
           8'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
